// File: rtl/crc_host_sequencer.sv
// Bus initiator that seeds and feeds the CRC peripheral from a job descriptor plus a
// valid/ready word stream, then reads back the DATA register as the job result.
module crc_host_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h4003_2000,
  parameter int unsigned GAP       = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] cfg_ctrl,
  input  logic [31:0] cfg_seed,
  input  logic [31:0] cfg_poly,
  output logic        busy,
  input  logic [31:0] din,
  input  logic        din_valid,
  input  logic        din_last,
  output logic        din_ready,
  output logic [31:0] result,
  output logic        result_valid,
  output logic [31:0] addr,
  output logic        RW,
  output logic        Sel,
  output logic [31:0] data_wr,
  input  logic [31:0] data_rd
);

  localparam logic [3:0] S_IDLE         = 4'd0;
  localparam logic [3:0] S_WR_CTRL_SEED = 4'd1;
  localparam logic [3:0] S_WR_POLY      = 4'd2;
  localparam logic [3:0] S_WR_SEED      = 4'd3;
  localparam logic [3:0] S_WR_CTRL_DATA = 4'd4;
  localparam logic [3:0] S_DATA_WAIT    = 4'd5;
  localparam logic [3:0] S_WR_DATA      = 4'd6;
  localparam logic [3:0] S_RD_RESULT    = 4'd7;
  localparam logic [3:0] S_DONE         = 4'd8;
  localparam logic [3:0] S_GAP_WAIT     = 4'd9;

  localparam logic [31:0] WAS_BIT  = 32'h0200_0000;
  localparam bit          NO_GAP   = (GAP == 0);
  localparam logic [3:0]  GAP_LOAD = 4'(GAP - 1);

  logic [3:0]  state, state_n;
  logic [3:0]  ret_state, ret_n;
  logic [3:0]  gap_cnt, gap_n;
  logic [3:0]  txn_next;
  logic        is_txn;
  logic [31:0] ctrl_q, seed_q, poly_q;
  logic        last_q;
  logic [31:0] ctrl_src;
  logic        sel_n, rw_n;
  logic [31:0] addr_n, wr_n;

  always_comb begin
    state_n  = state;
    ret_n    = ret_state;
    gap_n    = gap_cnt;
    is_txn   = 1'b0;
    txn_next = S_IDLE;
    case (state)
      S_IDLE:         if (start) state_n = S_WR_CTRL_SEED;
      S_WR_CTRL_SEED: begin is_txn = 1'b1; txn_next = S_WR_POLY; end
      S_WR_POLY:      begin is_txn = 1'b1; txn_next = S_WR_SEED; end
      S_WR_SEED:      begin is_txn = 1'b1; txn_next = S_WR_CTRL_DATA; end
      S_WR_CTRL_DATA: begin is_txn = 1'b1; txn_next = S_DATA_WAIT; end
      S_DATA_WAIT:    if (din_valid) state_n = S_WR_DATA;
      S_WR_DATA:      begin is_txn = 1'b1; txn_next = last_q ? S_RD_RESULT : S_DATA_WAIT; end
      S_RD_RESULT:    begin is_txn = 1'b1; txn_next = S_DONE; end
      S_DONE:         state_n = S_IDLE;
      S_GAP_WAIT: begin
        if (gap_cnt == '0) state_n = ret_state;
        else gap_n = gap_cnt - 4'd1;
      end
      default:        state_n = S_IDLE;
    endcase
    // Every bus transaction detours through GAP_WAIT and resumes at its successor.
    if (is_txn) begin
      if (NO_GAP) begin
        state_n = txn_next;
      end else begin
        state_n = S_GAP_WAIT;
        ret_n   = txn_next;
        gap_n   = GAP_LOAD;
      end
    end
  end

  // Bus outputs are registered from the next state, so the first CTRL write must
  // take the control word straight from the input in the accepting cycle.
  assign ctrl_src = (state == S_IDLE) ? cfg_ctrl : ctrl_q;

  always_comb begin
    sel_n  = 1'b0;
    rw_n   = 1'b0;
    addr_n = '0;
    wr_n   = '0;
    case (state_n)
      S_WR_CTRL_SEED: begin sel_n = 1'b1; rw_n = 1'b1; addr_n = BASE_ADDR + 32'h8; wr_n = ctrl_src | WAS_BIT; end
      S_WR_POLY:      begin sel_n = 1'b1; rw_n = 1'b1; addr_n = BASE_ADDR + 32'h4; wr_n = poly_q; end
      S_WR_SEED:      begin sel_n = 1'b1; rw_n = 1'b1; addr_n = BASE_ADDR;        wr_n = seed_q; end
      S_WR_CTRL_DATA: begin sel_n = 1'b1; rw_n = 1'b1; addr_n = BASE_ADDR + 32'h8; wr_n = ctrl_q & ~WAS_BIT; end
      S_WR_DATA:      begin sel_n = 1'b1; rw_n = 1'b1; addr_n = BASE_ADDR;        wr_n = din; end
      S_RD_RESULT:    begin sel_n = 1'b1; rw_n = 1'b0; addr_n = BASE_ADDR; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ret_state    <= S_IDLE;
      gap_cnt      <= '0;
      ctrl_q       <= '0;
      seed_q       <= '0;
      poly_q       <= '0;
      last_q       <= 1'b0;
      busy         <= 1'b0;
      din_ready    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      addr         <= '0;
      RW           <= 1'b0;
      Sel          <= 1'b0;
      data_wr      <= '0;
    end else begin
      state     <= state_n;
      ret_state <= ret_n;
      gap_cnt   <= gap_n;
      if (state == S_IDLE && start) begin
        ctrl_q <= cfg_ctrl;
        seed_q <= cfg_seed;
        poly_q <= cfg_poly;
      end
      if (state == S_DATA_WAIT && din_valid) last_q <= din_last;
      if (state == S_RD_RESULT) result <= data_rd;
      busy         <= (state_n != S_IDLE);
      din_ready    <= (state_n == S_DATA_WAIT);
      result_valid <= (state_n == S_DONE);
      Sel          <= sel_n;
      RW           <= rw_n;
      addr         <= addr_n;
      data_wr      <= wr_n;
    end
  end

endmodule

// File: tb/tb_crc_host_sequencer.sv
// Scoreboard bench: jobs push expected bus transactions and results; a monitor on the
// falling edge pops and compares whenever either instance (GAP=0, GAP=2) shows activity.
module tb_crc_host_sequencer;

  localparam logic [31:0] BASE = 32'h4003_2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start, din_valid, busy, din_ready, result_valid, rw, sel;
  logic [31:0] cfg_ctrl, cfg_seed, cfg_poly, din, rd_val;
  logic        din_last;
  logic [31:0] result [2];
  logic [31:0] addr [2];
  logic [31:0] data_wr [2];
  logic [31:0] data_rd [2];

  typedef struct { int d; int cyc; logic [31:0] addr; logic rw; logic [31:0] data; } bus_t;
  typedef struct { int d; int cyc; logic [31:0] val; } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  logic [31:0] job_words [8];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc_host_sequencer #(.BASE_ADDR(BASE), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .start(start[0]), .cfg_ctrl(cfg_ctrl), .cfg_seed(cfg_seed),
    .cfg_poly(cfg_poly), .busy(busy[0]), .din(din), .din_valid(din_valid[0]),
    .din_last(din_last), .din_ready(din_ready[0]), .result(result[0]),
    .result_valid(result_valid[0]), .addr(addr[0]), .RW(rw[0]), .Sel(sel[0]),
    .data_wr(data_wr[0]), .data_rd(data_rd[0]));

  crc_host_sequencer #(.BASE_ADDR(BASE), .GAP(2)) dut_g2 (
    .clk(clk), .rst(rst), .start(start[1]), .cfg_ctrl(cfg_ctrl), .cfg_seed(cfg_seed),
    .cfg_poly(cfg_poly), .busy(busy[1]), .din(din), .din_valid(din_valid[1]),
    .din_last(din_last), .din_ready(din_ready[1]), .result(result[1]),
    .result_valid(result_valid[1]), .addr(addr[1]), .RW(rw[1]), .Sel(sel[1]),
    .data_wr(data_wr[1]), .data_rd(data_rd[1]));

  // Read data is only meaningful during a read cycle; a distinctive filler elsewhere.
  assign data_rd[0] = (sel[0] && !rw[0]) ? rd_val : 32'h0BAD_F00D;
  assign data_rd[1] = (sel[1] && !rw[1]) ? rd_val : 32'h0BAD_F00D;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bus(input int d, input int c, input logic [31:0] a,
                          input logic w, input logic [31:0] v);
    bus_t e;
    e.d = d; e.cyc = c; e.addr = a; e.rw = w; e.data = v;
    bus_q.push_back(e);
  endtask

  bus_t me;
  res_t mr;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sel[d]) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: dut%0d addr %h got a transaction, expected none", d, addr[d]);
        end else begin
          me = bus_q.pop_front();
          check32("bus_dut", 32'(d), 32'(me.d));
          check32("bus_cycle", 32'(cyc), 32'(me.cyc));
          check32("bus_addr", addr[d], me.addr);
          check32("bus_rw", {31'd0, rw[d]}, {31'd0, me.rw});
          check32("bus_wdata", data_wr[d], me.data);
        end
      end else begin
        check32("idle_addr", addr[d], 32'h0);
        check32("idle_wdata", data_wr[d], 32'h0);
        check32("idle_rw", {31'd0, rw[d]}, 32'h0);
      end
      if (result_valid[d]) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL result_unexpected: dut%0d got result_valid, expected none", d);
        end else begin
          mr = res_q.pop_front();
          check32("res_dut", 32'(d), 32'(mr.d));
          check32("res_cycle", 32'(cyc), 32'(mr.cyc));
          check32("res_value", result[d], mr.val);
        end
      end
    end
  end

  // Schedule: one cycle per transaction followed by g idle cycles; each word is
  // taken on the first DATA_WAIT cycle unless the bench stalls it.
  task automatic run_job(input int d, input logic [31:0] ctrl, input logic [31:0] seed,
                         input logic [31:0] poly, input logic [31:0] exp_ctrl1,
                         input logic [31:0] exp_ctrl2, input int n, input int stall_idx,
                         input int stall_len, input logic [31:0] rdv, input int restart_at,
                         input bit bogus_din);
    int g, t0, cur, acc, w;
    res_t r;
    g = (d == 0) ? 0 : 2;
    rd_val = rdv;
    t0 = cyc;
    cfg_ctrl = ctrl; cfg_seed = seed; cfg_poly = poly;
    start[d] = 1'b1;
    if (bogus_din) begin
      din_valid[d] = 1'b1; din = 32'hFEED_0BAD; din_last = 1'b1;
    end
    cur = t0 + 1;
    push_bus(d, cur, BASE + 32'h8, 1'b1, exp_ctrl1); cur += 1 + g;
    push_bus(d, cur, BASE + 32'h4, 1'b1, poly);      cur += 1 + g;
    push_bus(d, cur, BASE,         1'b1, seed);      cur += 1 + g;
    push_bus(d, cur, BASE + 32'h8, 1'b1, exp_ctrl2); cur += 1 + g;
    for (int k = 0; k < n; k++) begin
      acc = cur + ((k == stall_idx) ? stall_len : 0);
      push_bus(d, acc + 1, BASE, 1'b1, job_words[k]);
      cur = acc + 2 + g;
    end
    push_bus(d, cur, BASE, 1'b0, 32'h0);
    r.d = d; r.cyc = cur + 1 + g; r.val = rdv;
    res_q.push_back(r);

    step();
    start[d] = 1'b0; din_valid[d] = 1'b0; din_last = 1'b0;
    check32("busy_after_start", {31'd0, busy[d]}, 32'h1);
    if (restart_at > 0) begin
      repeat (restart_at - 1) step();
      cfg_ctrl = 32'hFFFF_FFFF; cfg_seed = 32'h1111_1111; cfg_poly = 32'h2222_2222;
      start[d] = 1'b1;
      step();
      start[d] = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (!din_ready[d] && w < 200) begin step(); w++; end
      if (!din_ready[d]) begin
        checks++; errors++;
        $display("FAIL din_ready_timeout: dut%0d word %0d, got no din_ready, expected it", d, k);
        return;
      end
      if (k == stall_idx) repeat (stall_len) step();
      din = job_words[k]; din_last = (k == n - 1); din_valid[d] = 1'b1;
      step();
      din_valid[d] = 1'b0; din_last = 1'b0;
    end
    w = 0;
    while (busy[d] && w < 200) begin step(); w++; end
    check32("busy_cleared", {31'd0, busy[d]}, 32'h0);
    repeat (3) step();
    check32("result_hold", result[d], rdv);
  endtask

  initial begin
    rst = 1'b1; start = '0; din_valid = '0; din_last = 1'b0; din = '0;
    cfg_ctrl = '0; cfg_seed = '0; cfg_poly = '0; rd_val = '0;
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      check32("rst_sel", {31'd0, sel[d]}, 32'h0);
      check32("rst_busy", {31'd0, busy[d]}, 32'h0);
      check32("rst_din_ready", {31'd0, din_ready[d]}, 32'h0);
      check32("rst_result_valid", {31'd0, result_valid[d]}, 32'h0);
      check32("rst_result", result[d], 32'h0);
    end
    rst = 1'b0;
    step();

    // Basic trace, with din_valid asserted alongside start (must not be consumed).
    job_words[0] = 32'h3132_3334;
    run_job(0, 32'h0, 32'h0000_FFFF, 32'h0000_1021, 32'h0200_0000, 32'h0,
            1, -1, 0, 32'h0000_31C3, 0, 1'b1);

    // Control masking and readback capture.
    job_words[0] = 32'hA5A5_0001; job_words[1] = 32'h5A5A_0002;
    run_job(0, 32'h5700_0000, 32'hFFFF_FFFF, 32'h04C1_1DB7, 32'h5700_0000, 32'h5500_0000,
            2, -1, 0, 32'hDEAD_BEEF, 0, 1'b0);

    // Second start while busy must be ignored.
    job_words[0] = 32'h3132_3334;
    run_job(0, 32'h0, 32'h0000_FFFF, 32'h0000_1021, 32'h0200_0000, 32'h0,
            1, -1, 0, 32'h0000_31C3, 2, 1'b0);
    repeat (10) step();

    // Reset mid-job during DATA_WAIT, start during reset ignored, then restart.
    cfg_ctrl = 32'h0; cfg_seed = 32'h0000_ABCD; cfg_poly = 32'h0000_8005;
    start[0] = 1'b1;
    push_bus(0, cyc + 1, BASE + 32'h8, 1'b1, 32'h0200_0000);
    push_bus(0, cyc + 2, BASE + 32'h4, 1'b1, 32'h0000_8005);
    push_bus(0, cyc + 3, BASE,         1'b1, 32'h0000_ABCD);
    push_bus(0, cyc + 4, BASE + 32'h8, 1'b1, 32'h0);
    step();
    start[0] = 1'b0;
    for (int w = 0; w < 20 && !din_ready[0]; w++) step();
    check32("dw_before_rst", {31'd0, din_ready[0]}, 32'h1);
    rst = 1'b1;
    step();
    check32("midrst_sel", {31'd0, sel[0]}, 32'h0);
    check32("midrst_busy", {31'd0, busy[0]}, 32'h0);
    check32("midrst_din_ready", {31'd0, din_ready[0]}, 32'h0);
    step();
    start[0] = 1'b1;
    step();
    rst = 1'b0; start[0] = 1'b0;
    step();
    check32("start_in_rst_ignored", {31'd0, busy[0]}, 32'h0);
    step();
    job_words[0] = 32'h0000_0055;
    run_job(0, 32'h0, 32'h0000_ABCD, 32'h0000_8005, 32'h0200_0000, 32'h0,
            1, -1, 0, 32'h1357_9BDF, 0, 1'b0);

    // GAP=2, four words, five-cycle stall before word 2.
    job_words[0] = 32'h1111_0000; job_words[1] = 32'h2222_0001;
    job_words[2] = 32'h3333_0002; job_words[3] = 32'h4444_0003;
    run_job(1, 32'hA400_0000, 32'h0000_0000, 32'h1EDC_6F41, 32'hA600_0000, 32'hA400_0000,
            4, 2, 5, 32'h1234_5678, 0, 1'b0);

    repeat (10) step();
    check32("bus_queue_drained", 32'(bus_q.size()), 32'h0);
    check32("res_queue_drained", 32'(res_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/crc_host_sequencer.md
# crc_host_sequencer

Bus initiator that drives the CRC peripheral's register interface (DATA at BASE+0x0, GPOLY at BASE+0x4, CTRL at BASE+0x8). It accepts a job (control word, seed, polynomial) plus a valid/ready stream of 32-bit data words. It then issues the register-write sequence that seeds and feeds the CRC engine, reads back the DATA register, and returns that value as the job result. It sits between a DMA/stream source and the CRC peripheral, on the same single-cycle select/read-write bus.

## Interface
- BASE_ADDR, 32'h4003_2000, CRC register base; DATA=BASE, GPOLY=BASE+4, CTRL=BASE+8
- GAP, 0, idle cycles (Sel=0) inserted after every bus transaction; range 0..15
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  job request; accepted only in IDLE
- cfg_ctrl  in  32  CTRL image (TOT[31:30], TOTR[29:28], FXOR[26], TCRC[24]); sampled on accepted start
- cfg_seed  in  32  seed; sampled on accepted start
- cfg_poly  in  32  polynomial; sampled on accepted start
- busy  out  1  high from cycle after accepted start through result_valid cycle
- din  in  32  data word
- din_valid  in  1  data word valid
- din_last  in  1  qualifies final word of job
- din_ready  out  1  high only in DATA_WAIT
- result  out  32  DATA register readback; holds until next result_valid
- result_valid  out  1  one-cycle pulse
- addr  out  32  bus address
- RW  out  1  1=write, 0=read
- Sel  out  1  bus select; exactly one cycle per transaction
- data_wr  out  32  write data
- data_rd  in  32  read data; combinational from peripheral, valid while Sel=1, RW=0

## Operation
- All outputs registered. Reset value: every output 0, FSM in IDLE, GAP counter 0, captured config 0.
- FSM states: IDLE, WR_CTRL_SEED, WR_POLY, WR_SEED, WR_CTRL_DATA, DATA_WAIT, WR_DATA, RD_RESULT, DONE, plus GAP_WAIT between transactions when GAP>0.
- IDLE: on start=1, capture cfg_*, go to WR_CTRL_SEED. start in any other state is ignored (no queuing).
- WR_CTRL_SEED: addr=BASE+8, RW=1, data_wr=cfg_ctrl|32'h0200_0000 (WAS=1).
- WR_POLY: addr=BASE+4, data_wr=cfg_poly.
- WR_SEED: addr=BASE, data_wr=cfg_seed.
- WR_CTRL_DATA: addr=BASE+8, data_wr=cfg_ctrl & ~32'h0200_0000 (WAS=0).
- DATA_WAIT: din_ready=1, Sel=0. On din_valid: latch din and din_last, go to WR_DATA.
- WR_DATA: addr=BASE, RW=1, data_wr=latched word. If latched last=1, go to RD_RESULT; otherwise go to DATA_WAIT.
- RD_RESULT: addr=BASE, RW=0, Sel=1, data_wr=0. Capture data_rd into result at the end of this cycle.
- DONE: result_valid=1 for one cycle, then IDLE. busy drops in the same cycle DONE exits.
- Outside a transaction cycle: Sel=0, RW=0, addr and data_wr=0.
- A job always carries ≥1 word; there is no empty-job path.
- din_last is sampled only with the handshake.

## Timing
- GAP=0, start accepted at cycle 0: CTRL(WAS=1) in c1, POLY in c2, SEED in c3, CTRL(WAS=0) in c4, DATA_WAIT in c5.
- With din_valid held high, word k (k=0..N-1) is accepted at c5+2k and written at c6+2k. Read occurs at c5+2N; result_valid at c6+2N.
- Max data throughput is 1 word per 2 cycles.
- GAP>0: GAP idle cycles (Sel=0) follow every transaction, including the read. Each step shifts by GAP.
- din_valid low in DATA_WAIT: stall indefinitely, with Sel=0 and no bus activity.
- rst=1 in any cycle: next cycle all outputs are 0 and the FSM is in IDLE. A partially issued sequence is abandoned with no completing transaction. start sampled in the same cycle as rst is ignored.
- start and din_valid in the same IDLE cycle: din is not consumed (din_ready=0 in IDLE).

## Test plan
- Reset: hold rst 3 cycles mid-job (during DATA_WAIT). Required: Sel=0, busy=0, din_ready=0 the next cycle; a following start restarts from WR_CTRL_SEED.
- Basic trace, GAP=0: cfg_ctrl=0x0000_0000, seed=0x0000_FFFF, poly=0x0000_1021, one word 0x3132_3334 with last. Required bus trace: (0x40032008,W,0x02000000) c1, (0x40032004,W,0x00001021) c2, (0x40032000,W,0x0000FFFF) c3, (0x40032008,W,0x0) c4, (0x40032000,W,0x31323334) c6, read c7. result_valid at c8.
- Control masking: cfg_ctrl=0x5700_0000. Required: first CTRL write 0x5700_0000, second CTRL write 0x5500_0000.
- Readback capture: bench responder drives data_rd=0xDEAD_BEEF only while Sel=1, RW=0. Required: result=0xDEADBEEF with a one-cycle result_valid, and result held afterward.
- Back-pressure/GAP: GAP=2, 4 words, din_valid low for 5 cycles before word 2. Required: exactly 2 idle cycles after each transaction, no bus activity during the stall, 4 data writes in order, a single read.
- Busy rejection: pulse start again while busy. Required: the bus trace is identical to the single-job trace, and no second sequence follows.
